// File: rtl/da_shift_accumulator_mc.sv
// Multi-channel serial (LSB-first) shift-accumulator for the distributed-arithmetic filter datapath.
// Optional build macro DA_ACC_SAT_EN: clamp add/subtract to the signed DATA_W range instead of wrapping.
module da_shift_accumulator_mc #(
  parameter int DATA_W   = 40,
  parameter int IN_W     = 16,
  parameter int ALIGN    = 16,
  parameter int NBITS    = 16,
  parameter int CHANNELS = 2,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                sclk,
  input  logic                reset,
  input  logic                start,
  input  logic [CH_W-1:0]     start_ch,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [IN_W-1:0]     in_data,
  output logic [CHANNELS-1:0] busy,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  output logic [DATA_W-1:0]   out_data
);

  localparam int CNT_W = $clog2(NBITS);
  localparam int EXT_W = DATA_W - IN_W - ALIGN;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);
`ifdef DA_ACC_SAT_EN
  localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  typedef enum logic {IDLE, ACCUM} state_t;

  // Partial sum placed at its bit weight, sign-extended to the full accumulator.
  logic [DATA_W-1:0] addend;
  assign addend = {{EXT_W{in_data[IN_W-1]}}, in_data, {ALIGN{1'b0}}};

  // Input carries one guard bit; disagreement between the top two bits means overflow.
  function automatic logic [DATA_W-1:0] clamp(input logic [DATA_W:0] wide);
`ifdef DA_ACC_SAT_EN
    if (wide[DATA_W] != wide[DATA_W-1])
      return wide[DATA_W] ? MIN_VAL : MAX_VAL;
`endif
    return wide[DATA_W-1:0];
  endfunction

  logic [CHANNELS-1:0] done_vec;
  logic [DATA_W-1:0]   final_acc [CHANNELS];
  logic [DATA_W-1:0]   result_sel;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      state_t            state_reg, state_next;
      logic [DATA_W-1:0] acc_reg, acc_next, sum_val, diff_val;
      logic [CNT_W-1:0]  cnt_reg, cnt_next;
      logic              hit_start, hit_beat, done;

      // A start aimed at this channel shadows a same-cycle beat for it.
      assign hit_start = start && (start_ch == CH_W'(gi));
      assign hit_beat  = in_valid && (in_ch == CH_W'(gi)) && !hit_start && (state_reg == ACCUM);

      assign sum_val  = clamp({acc_reg[DATA_W-1], acc_reg} + {addend[DATA_W-1], addend});
      assign diff_val = clamp({acc_reg[DATA_W-1], acc_reg} - {addend[DATA_W-1], addend});

      always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        done       = 1'b0;
        if (hit_start) begin
          state_next = ACCUM;
          acc_next   = '0;
          cnt_next   = '0;
        end else if (hit_beat) begin
          if (cnt_reg == LAST_CNT) begin
            state_next = IDLE;
            acc_next   = diff_val;
            done       = 1'b1;
          end else begin
            acc_next = {sum_val[DATA_W-1], sum_val[DATA_W-1:1]};
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      always_ff @(negedge sclk) begin
        if (reset) begin
          state_reg <= IDLE;
          acc_reg   <= '0;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          acc_reg   <= acc_next;
          cnt_reg   <= cnt_next;
        end
      end

      assign done_vec[gi]  = done;
      assign final_acc[gi] = diff_val;
      assign busy[gi]      = (state_reg == ACCUM);
    end
  endgenerate

  // At most one channel finishes per cycle (one beat per cycle), so OR-merging is safe.
  always_comb begin
    result_sel = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (done_vec[c]) result_sel = result_sel | final_acc[c];
  end

  always_ff @(negedge sclk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= |done_vec;
      if (|done_vec) begin
        out_ch   <= in_ch;
        out_data <= result_sel;
      end
    end
  end

endmodule
